dcache_wb: RTL and testbench

Direct-mapped, write-back, write-allocate data cache between the pipelined MIPS core's memory stage and a slow block-wide main memory. It answers word reads and writes from the core in the same cycle on a hit. On a miss it raises `proc_stall`, writes back a dirty victim if there is one, refills the block, and releases the stall once the access hits. The same block serves as the instruction-side cache when `proc_wen` is tied low.

---
 rtl/dcache_pkg.sv | 33 +++
 rtl/dcache_store.sv | 60 ++++++
 rtl/dcache_wb.sv | 113 +++++++++++
 tb/tb_dcache_wb.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and address helpers for the write-back data cache.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package dcache_pkg;

  localparam int WORD_W      = 32;
  localparam int BLOCK_W     = 128;
  localparam int PROC_ADDR_W = 30;
  localparam int MEM_ADDR_W  = 28;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  // Word offset within a 4-word block.
  function automatic logic [1:0] addr_offset(input logic [PROC_ADDR_W-1:0] addr);
    return addr[1:0];
  endfunction

  // Block address {tag, index}; callers split it at their own INDEX_W.
  function automatic logic [MEM_ADDR_W-1:0] addr_block(input logic [PROC_ADDR_W-1:0] addr);
    return addr[PROC_ADDR_W-1:2];
  endfunction

  // Select one word of a block; word 0 lives in the low bits.
  function automatic logic [WORD_W-1:0] block_word(input logic [BLOCK_W-1:0] blk,
                                                   input logic [1:0]         off);
    return blk[{off, 5'b00000} +: WORD_W];
  endfunction

endpackage

// File: rtl/dcache_store.sv
// Valid/dirty/tag/data arrays for the direct-mapped cache.
// Latency: asynchronous read by index, writes land on the rising edge.
// Backpressure: none; word write and block fill are mutually exclusive (fill wins).
module dcache_store
  import dcache_pkg::*;
#(
  parameter int INDEX_W = 3,
  parameter int TAG_W   = 28 - INDEX_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] idx,
  output logic               rd_valid,
  output logic               rd_dirty,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [BLOCK_W-1:0] rd_data,
  input  logic               word_we,
  input  logic [1:0]         word_off,
  input  logic [WORD_W-1:0]  word_dat,
  input  logic               fill_we,
  input  logic [TAG_W-1:0]   fill_tag,
  input  logic [BLOCK_W-1:0] fill_data
);

  localparam int NBLK = 1 << INDEX_W;

  logic [NBLK-1:0]    valid_q;
  logic [NBLK-1:0]    dirty_q;
  logic [TAG_W-1:0]   tag_q  [NBLK];
  logic [BLOCK_W-1:0] data_q [NBLK];

  // Line status bits: cleared by reset, fill makes a line valid+clean, word write dirties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (word_we) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Tag and data storage: no reset, contents only matter behind a valid bit.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[idx]  <= fill_tag;
      data_q[idx] <= fill_data;
    end else if (word_we) begin
      data_q[idx][{word_off, 5'b00000} +: WORD_W] <= word_dat;
    end
  end

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_data  = data_q[idx];

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped write-back, write-allocate cache between core and block memory.
// Latency: hits complete in the same cycle; misses stall 1+L (clean) or 1+Lw+Lr (dirty).
// Backpressure: proc_stall holds the core; mem_read/mem_write held until mem_ready.
module dcache_wb
  import dcache_pkg::*;
#(
  parameter  int INDEX_W = 3,
  localparam int TAG_W   = 28 - INDEX_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   proc_ren,
  input  logic                   proc_wen,
  input  logic [PROC_ADDR_W-1:0] proc_addr,
  input  logic [WORD_W-1:0]      proc_wdata,
  output logic                   proc_stall,
  output logic [WORD_W-1:0]      proc_rdata,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [MEM_ADDR_W-1:0]  mem_addr,
  output logic [BLOCK_W-1:0]     mem_wdata,
  input  logic                   mem_ready,
  input  logic [BLOCK_W-1:0]     mem_rdata
);

  state_t state_q, state_d;

  logic [MEM_ADDR_W-1:0] blk_addr;
  logic [INDEX_W-1:0]    idx;
  logic [TAG_W-1:0]      req_tag;
  logic [1:0]            off;

  logic               rd_valid, rd_dirty;
  logic [TAG_W-1:0]   rd_tag;
  logic [BLOCK_W-1:0] rd_data;
  logic               word_we, fill_we;
  logic               req, hit;

  assign blk_addr = addr_block(proc_addr);
  assign idx      = blk_addr[INDEX_W-1:0];
  assign req_tag  = blk_addr[MEM_ADDR_W-1:INDEX_W];
  assign off      = addr_offset(proc_addr);

  // The core holds the request during a stall, so the index never moves mid-miss.
  dcache_store #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_store (
    .clk       (clk),
    .rst_n     (rst_n),
    .idx       (idx),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .word_we   (word_we),
    .word_off  (off),
    .word_dat  (proc_wdata),
    .fill_we   (fill_we),
    .fill_tag  (req_tag),
    .fill_data (mem_rdata)
  );

  assign req        = proc_ren | proc_wen;
  assign hit        = rd_valid && (rd_tag == req_tag);
  assign proc_rdata = block_word(rd_data, off);

  // Miss-handling state register; reset abandons any memory transaction at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, memory handshake and array write strobes.
  always_comb begin
    state_d    = state_q;
    proc_stall = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    word_we    = 1'b0;
    fill_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && !hit) begin
          proc_stall = 1'b1;
          state_d    = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
        end else if (proc_wen && hit) begin
          word_we = 1'b1;
        end
      end
      WRITEBACK: begin
        proc_stall = 1'b1;
        mem_write  = 1'b1;
        mem_addr   = {rd_tag, idx};
        mem_wdata  = rd_data;
        if (mem_ready) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        proc_stall = 1'b1;
        mem_read   = 1'b1;
        mem_addr   = {req_tag, idx};
        if (mem_ready) begin
          fill_we = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_wb.sv
// Randomized bench for dcache_wb against a flat-memory reference view.
// Latency: memory responder uses random 1..4 cycle latency unless forced.
// Backpressure: core side waits on proc_stall with a bounded cycle budget.
module tb_dcache_wb;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         proc_ren = 1'b0, proc_wen = 1'b0;
  logic [29:0]  proc_addr = '0;
  logic [31:0]  proc_wdata = '0;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_ready;
  logic [127:0] mem_rdata;

  always #5 clk = ~clk;

  dcache_wb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .proc_ren   (proc_ren),
    .proc_wen   (proc_wen),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_stall (proc_stall),
    .proc_rdata (proc_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Backing store seen by the memory responder, and the core's coherent view of memory.
  logic [31:0] phys_word [logic [29:0]];
  logic [31:0] ref_word  [logic [29:0]];

  function automatic logic [31:0] def_word(input logic [29:0] a);
    return {a, 2'b11} ^ 32'h5EED_0000;
  endfunction
  function automatic logic [31:0] phys_get(input logic [29:0] a);
    return phys_word.exists(a) ? phys_word[a] : def_word(a);
  endfunction
  function automatic logic [31:0] ref_get(input logic [29:0] a);
    return ref_word.exists(a) ? ref_word[a] : def_word(a);
  endfunction

  // Which block each cache line holds, per the cache rules.
  bit          mv [8];
  bit          md [8];
  logic [24:0] mt [8];

  int force_lat = 0;
  int lat_w_used = 0, lat_r_used = 0;
  int spur_req = 0, spur_seen = 0;

  initial begin
    int cyc = 0;
    int cur_lat = 1;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (spur_req != spur_seen) begin
        spur_seen = spur_req;
        mem_ready = 1'b1;
        mem_rdata = {4{32'hBAD0_BAD0}};
      end else if (rst_n && (mem_read || mem_write)) begin
        if (cyc == 0) cur_lat = (force_lat != 0) ? force_lat : int'($urandom_range(1, 4));
        cyc++;
        if (cyc >= cur_lat) begin
          if (mem_write) begin
            for (int w = 0; w < 4; w++) phys_word[{mem_addr, 2'(w)}] = mem_wdata[w*32 +: 32];
            lat_w_used = cur_lat;
          end else begin
            for (int w = 0; w < 4; w++) mem_rdata[w*32 +: 32] = phys_get({mem_addr, 2'(w)});
            lat_r_used = cur_lat;
          end
          mem_ready = 1'b1;
          cyc = 0;
        end
      end else begin
        cyc = 0;
      end
    end
  end

  task automatic finish_run();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  endtask

  // One core access: apply at a falling edge, wait out the stall, check against the model.
  task automatic access(input bit we, input logic [29:0] a, input logic [31:0] d,
                        output int stalls, output logic [31:0] rdata, output bit saw_wb,
                        output logic [27:0] wb_a, output logic [127:0] wb_d, output logic [27:0] rd_a);
    logic [2:0]   ix;
    logic [24:0]  t;
    bit           hit, dmiss, saw_rd, both;
    logic [127:0] exp_wb;
    int           exp_stall;
    ix = a[4:2];
    t  = a[29:5];
    hit   = mv[ix] && (mt[ix] == t);
    dmiss = !hit && mv[ix] && md[ix];
    for (int w = 0; w < 4; w++) exp_wb[w*32 +: 32] = ref_get({mt[ix], ix, 2'(w)});
    saw_wb = 1'b0; saw_rd = 1'b0; both = 1'b0;
    wb_a = '0; wb_d = '0; rd_a = '0; stalls = 0;
    @(negedge clk);
    proc_wen = we; proc_ren = !we; proc_addr = a; proc_wdata = d;
    #1;
    while (proc_stall && stalls < 200) begin
      if (mem_write && !saw_wb) begin saw_wb = 1'b1; wb_a = mem_addr; wb_d = mem_wdata; end
      if (mem_read && !saw_rd) begin saw_rd = 1'b1; rd_a = mem_addr; end
      if (mem_read && mem_write) both = 1'b1;
      stalls++;
      @(negedge clk); #1;
    end
    exp_stall = hit ? 0 : 1 + (dmiss ? lat_w_used : 0) + lat_r_used;
    chk("stall_cycles", stalls, exp_stall);
    if (stalls >= 200) begin
      $display("FAIL access_timeout: stall still high after %0d cycles, required release", stalls);
      finish_run();
    end
    chk("writeback_seen", saw_wb, dmiss);
    chk("refill_seen", saw_rd, !hit);
    chk("rd_wr_exclusive", both, 1'b0);
    if (dmiss) begin
      chk("wb_addr", wb_a, {mt[ix], ix});
      chk("wb_data", wb_d, exp_wb);
    end
    if (!hit) chk("refill_addr", rd_a, {t, ix});
    chk("mem_idle_on_hit", {mem_read, mem_write}, 2'b00);
    rdata = proc_rdata;
    if (!we) chk("rdata", proc_rdata, ref_get(a));
    if (!hit) begin mv[ix] = 1'b1; md[ix] = 1'b0; mt[ix] = t; end
    if (we) begin md[ix] = 1'b1; ref_word[a] = d; end
  endtask

  // Reset loses dirty lines: the core's view falls back to what memory holds.
  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      if (mv[i] && md[i])
        for (int w = 0; w < 4; w++) ref_word[{mt[i], 3'(i), 2'(w)}] = phys_get({mt[i], 3'(i), 2'(w)});
      mv[i] = 1'b0; md[i] = 1'b0;
    end
  endtask

  initial begin
    int           st;
    logic [31:0]  rd;
    bit           swb;
    logic [27:0]  wa, ra;
    logic [127:0] wd;
    logic [29:0]  a;
    for (int i = 0; i < 8; i++) begin mv[i] = 1'b0; md[i] = 1'b0; mt[i] = '0; end

    // Reset state with no request.
    #12;
    @(negedge clk); rst_n = 1'b1; #1;
    chk("reset_stall", proc_stall, 1'b0);
    chk("reset_mem_read", mem_read, 1'b0);
    chk("reset_mem_write", mem_write, 1'b0);
    chk("reset_mem_addr", mem_addr, 28'h0);
    chk("reset_mem_wdata", mem_wdata, 128'h0);

    // Cold read miss with L=3 on block 1.
    for (int w = 0; w < 4; w++) begin
      phys_word[30'h4 + 30'(w)] = 32'h11 * (w + 1);
      ref_word[30'h4 + 30'(w)]  = 32'h11 * (w + 1);
    end
    force_lat = 3;
    access(1'b0, 30'h5, 32'h0, st, rd, swb, wa, wd, ra);
    chk("cold_stall", st, 4);
    chk("cold_addr", ra, 28'h1);
    chk("cold_rdata", rd, 32'h22);
    force_lat = 0;

    // Write hit, then eviction of the dirty line by a same-index read.
    access(1'b1, 30'h5, 32'hDEAD_BEEF, st, rd, swb, wa, wd, ra);
    chk("wr_hit_stall", st, 0);
    access(1'b0, 30'h25, 32'h0, st, rd, swb, wa, wd, ra);
    chk("evict_wb", swb, 1'b1);
    chk("evict_wb_addr", wa, 28'h1);
    chk("evict_wb_word1", wd[63:32], 32'hDEAD_BEEF);
    chk("evict_refill_addr", ra, 28'h9);

    // Write miss to a clean valid line: no writeback, then the word reads back.
    access(1'b0, 30'h0A, 32'h0, st, rd, swb, wa, wd, ra);
    access(1'b1, 30'h28, 32'hCAFE_F00D, st, rd, swb, wa, wd, ra);
    chk("clean_wmiss_no_wb", swb, 1'b0);
    access(1'b0, 30'h28, 32'h0, st, rd, swb, wa, wd, ra);
    chk("clean_wmiss_readback", rd, 32'hCAFE_F00D);

    // Back-to-back hits on four resident lines.
    for (int i = 0; i < 4; i++) access(1'b0, 30'h10 + 30'(4 * i), 32'h0, st, rd, swb, wa, wd, ra);
    for (int i = 0; i < 20; i++) begin
      a = 30'h10 + 30'(4 * (i % 4)) + 30'($urandom_range(0, 3));
      access(1'(i % 2), a, $urandom, st, rd, swb, wa, wd, ra);
      chk("b2b_stall", st, 0);
    end

    // Spurious mem_ready while idle must not disturb anything.
    @(negedge clk); proc_ren = 1'b0; proc_wen = 1'b0;
    spur_req++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("spur_no_stall", proc_stall, 1'b0);
    end
    access(1'b0, 30'h14, 32'h0, st, rd, swb, wa, wd, ra);
    chk("spur_still_hit", st, 0);

    // Reset in the middle of a refill.
    force_lat = 50;
    @(negedge clk); proc_ren = 1'b1; proc_wen = 1'b0; proc_addr = 30'h2C;
    for (int i = 0; i < 20 && !mem_read; i++) begin @(negedge clk); #1; end
    chk("alloc_reached", mem_read, 1'b1);
    #2; rst_n = 1'b0; #1;
    chk("rst_drops_mem_read", mem_read, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_stall_on_miss", proc_stall, 1'b1);
    model_reset();
    proc_ren = 1'b0;
    @(negedge clk); rst_n = 1'b1; force_lat = 0;
    access(1'b0, 30'h2C, 32'h0, st, rd, swb, wa, wd, ra);
    chk("rst_remiss", (st > 0), 1'b1);

    // Randomized mix over a small tag space to force hits, thrashing and evictions.
    for (int i = 0; i < 300; i++) begin
      a = {25'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      access(1'($urandom_range(0, 1)), a, $urandom, st, rd, swb, wa, wd, ra);
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk); proc_ren = 1'b0; proc_wen = 1'b0;
      end
    end

    @(negedge clk); proc_ren = 1'b0; proc_wen = 1'b0;
    finish_run();
  end

endmodule
